// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter that shares one byte-level UART transmitter among NREQ sources.
// One byte in flight at a time; an idle gap of GAP cycles separates consecutive frames.
module uart_tx_arbiter #(
    parameter int NREQ      = 3,
    parameter int MAX_BYTES = 40,
    parameter int GAP       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     src_valid,
    input  logic [NREQ*8-1:0]   src_data,
    input  logic [NREQ-1:0]     src_last,
    output logic [NREQ-1:0]     src_ready,
    output logic [NREQ-1:0]     gnt,
    output logic                uart_send,
    output logic [7:0]          send_data,
    input  logic                uart_send_done,
    output logic                busy,
    output logic                frame_trunc
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BYTES);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0] RR_INIT  = IW'(NREQ - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]      r_state;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_rr;
    logic [CW-1:0]   r_count;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_last;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_src_ready;
    logic            r_uart_send;
    logic [7:0]      r_send_data;
    logic            r_busy;
    logic            r_trunc;

    logic [IW-1:0]   w_pick;
    logic [IW-1:0]   w_cand;
    logic            w_any;

    // Walk downward so the candidate closest after r_rr is the one left standing.
    always_comb begin
        w_pick = r_rr;
        w_cand = r_rr;
        w_any  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IW'((int'(r_rr) + k) % NREQ);
            if (req[w_cand]) begin
                w_pick = w_cand;
                w_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gidx      <= '0;
            r_rr        <= RR_INIT;
            r_count     <= '0;
            r_gap_cnt   <= '0;
            r_last      <= 1'b0;
            r_gnt       <= '0;
            r_src_ready <= '0;
            r_uart_send <= 1'b0;
            r_send_data <= '0;
            r_busy      <= 1'b0;
            r_trunc     <= 1'b0;
        end else begin
            r_src_ready <= '0;
            r_trunc     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= NREQ'(1) << w_pick;
                        r_gidx  <= w_pick;
                        r_rr    <= w_pick;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (src_valid[r_gidx]) begin
                        r_send_data <= src_data[{r_gidx, 3'b000} +: 8];
                        r_last      <= src_last[r_gidx];
                        r_src_ready <= NREQ'(1) << r_gidx;
                        r_count     <= r_count + 1'b1;
                        r_uart_send <= 1'b1;
                        r_state     <= S_SEND;
                    end else if (!req[r_gidx]) begin
                        // Source withdrew mid-frame with nothing pending: abandon the frame.
                        r_gnt     <= '0;
                        r_gap_cnt <= '0;
                        if (GAP == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_SEND: begin
                    if (uart_send_done) begin
                        r_uart_send <= 1'b0;
                        if (r_last || (r_count == CNT_MAX)) begin
                            r_trunc   <= !r_last;
                            r_gnt     <= '0;
                            r_gap_cnt <= '0;
                            if (GAP == 0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready   = r_src_ready;
    assign gnt         = r_gnt;
    assign uart_send   = r_uart_send;
    assign send_data   = r_send_data;
    assign busy        = r_busy;
    assign frame_trunc = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural sources and UART drive the DUT; a stream/round-robin
// reference model predicts grants, bytes, truncation pulses and inter-frame gaps.
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int MAXB = 4;
    localparam int GAPC = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     src_valid;
    logic [NREQ*8-1:0]   src_data;
    logic [NREQ-1:0]     src_last;
    logic [NREQ-1:0]     src_ready;
    logic [NREQ-1:0]     gnt;
    logic                uart_send;
    logic [7:0]          send_data;
    logic                uart_send_done;
    logic                busy;
    logic                frame_trunc;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BYTES(MAXB), .GAP(GAPC)) dut (
        .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(src_ready), .gnt(gnt), .uart_send(uart_send),
        .send_data(send_data), .uart_send_done(uart_send_done), .busy(busy),
        .frame_trunc(frame_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic last; } ent_t;

    ent_t drv_q[NREQ][$];
    ent_t mdl_q[NREQ][$];

    int n_checks, n_errors;
    int m_rr, m_src, m_cnt, uart_wait, gcnt, stall_pct, trunc_seen;
    bit m_active, m_final, m_trunc, real_done_prev, gap_run, hold_valid;
    logic [NREQ-1:0] p_gnt;
    logic            p_send;
    logic [7:0]      m_cur;
    int              glog[$];
    logic [7:0]      blog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int s);
        if (s < 0) return '0;
        return NREQ'(1) << s;
    endfunction

    // Next requester after the most recently served source.
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic push(input int s, input logic [7:0] d, input logic l);
        ent_t e;
        e.data = d;
        e.last = l;
        drv_q[s].push_back(e);
        mdl_q[s].push_back(e);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            ent_t h;
            h = '0;
            if (drv_q[i].size() > 0) h = drv_q[i][0];
            req[i]       = (drv_q[i].size() > 0);
            src_valid[i] = req[i] && !hold_valid && (int'($urandom_range(99, 0)) >= stall_pct);
            src_data[i*8 +: 8] = h.data;
            src_last[i]  = h.last;
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NREQ; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        m_rr = NREQ - 1; m_src = -1; m_cnt = 0; m_cur = '0;
        m_active = 0; m_final = 0; m_trunc = 0; real_done_prev = 0;
        p_gnt = '0; p_send = 1'b0; uart_wait = -1; gap_run = 0; gcnt = 0;
        uart_send_done = 1'b0;
        drive_inputs();
    endtask

    task automatic cycle();
        bit rise_send, ended;
        int e;
        @(posedge clk);
        #1;
        rise_send = uart_send && !p_send;
        ended = 0;
        chk("frame_trunc", frame_trunc, real_done_prev && m_final && m_trunc);
        if (frame_trunc) trunc_seen++;
        if (real_done_prev) begin
            chk("send_drop", uart_send, 0);
            if (m_final) begin
                chk("gnt_end", gnt, 0);
                m_active = 0; m_final = 0; ended = 1;
            end else begin
                chk("gnt_hold", gnt, oh(m_src));
            end
        end
        if (p_gnt != 0 && gnt == 0 && !ended) begin
            chk("abandon_active", m_active, 1);
            if (m_src >= 0) chk("abandon_empty", mdl_q[m_src].size(), 0);
            m_active = 0; m_final = 0;
        end
        if (p_gnt == 0 && gnt != 0) begin
            e = pick(req, m_rr);
            chk("grant", gnt, oh(e));
            if (e >= 0) begin m_rr = e; m_src = e; end
            m_cnt = 0; m_active = 1;
            glog.push_back(idx_of(gnt));
        end
        chk("src_ready", src_ready, (rise_send && m_active) ? oh(m_src) : '0);
        if (rise_send) begin
            if (m_active && m_src >= 0 && mdl_q[m_src].size() > 0) begin
                ent_t b;
                b = mdl_q[m_src].pop_front();
                chk("send_data", send_data, b.data);
                m_cur = b.data;
                m_cnt++;
                m_final = b.last || (m_cnt == MAXB);
                m_trunc = !b.last && (m_cnt == MAXB);
                blog.push_back(send_data);
            end else begin
                chk("unexpected_send", uart_send, 0);
            end
        end else if (uart_send) begin
            chk("send_data_stable", send_data, m_cur);
        end
        if (uart_send) chk("send_gnt", gnt, oh(m_active ? m_src : -1));
        if (gnt != 0) chk("busy", busy, 1);
        if (gap_run) begin
            if (busy) gcnt++;
            else begin
                chk("gap_len", gcnt, GAPC);
                gap_run = 0;
            end
        end
        if (p_gnt != 0 && gnt == 0) begin
            gap_run = 1;
            gcnt = int'(busy);
        end
        for (int i = 0; i < NREQ; i++)
            if (src_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        uart_send_done = 1'b0;
        real_done_prev = 0;
        if (uart_send) begin
            if (uart_wait < 0) uart_wait = int'($urandom_range(3, 0));
            if (uart_wait == 0) begin
                uart_send_done = 1'b1;
                real_done_prev = 1;
                uart_wait = -1;
            end else begin
                uart_wait--;
            end
        end else if ($urandom_range(99, 0) < 5) begin
            uart_send_done = 1'b1;
        end
        p_gnt = gnt;
        p_send = uart_send;
        drive_inputs();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (drv_q[i].size() > 0) return 0;
        return 1;
    endfunction

    task automatic run_until_idle(input string tag, input int maxc);
        bit reached;
        int left;
        reached = 0;
        for (int n = 0; n < maxc && !reached; n++) begin
            cycle();
            if (all_empty() && busy === 1'b0 && gnt === '0 && !gap_run) reached = 1;
        end
        chk({tag, "_idle_reached"}, reached, 1);
        left = 0;
        for (int i = 0; i < NREQ; i++) left += mdl_q[i].size();
        chk({tag, "_drained"}, left, 0);
    endtask

    task automatic clear_logs();
        glog.delete();
        blog.delete();
        trunc_seen = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_exp[6];
        bit seen;
        n_checks = 0; n_errors = 0; stall_pct = 0; hold_valid = 0;
        rst = 1'b1;
        reset_model();
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_send", uart_send, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc", frame_trunc, 0);
        chk("rst_data", send_data, 0);
        @(negedge clk) rst = 1'b0;

        // Reset while a byte is in flight
        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
        drive_inputs();
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            cycle();
            if (uart_send === 1'b1) seen = 1;
        end
        chk("midsend_reached", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_send", uart_send, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_ready", src_ready, 0);
        chk("midrst_busy", busy, 0);
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Round-robin with all three requesting
        clear_logs();
        push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b1); push(1, 8'h21, 1'b1);
        push(2, 8'h30, 1'b1); push(2, 8'h31, 1'b1);
        drive_inputs();
        run_until_idle("rr", 2000);
        rr_exp = '{0, 1, 2, 0, 1, 2};
        chk("rr_frames", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], rr_exp[i]);

        // Single two-byte frame from source 1
        clear_logs();
        push(1, 8'hA5, 1'b0); push(1, 8'h3C, 1'b1);
        drive_inputs();
        run_until_idle("single", 500);
        chk("single_frames", glog.size(), 1);
        if (glog.size() > 0) chk("single_src", glog[0], 1);
        chk("single_bytes", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("single_b0", blog[0], 8'hA5);
            chk("single_b1", blog[1], 8'h3C);
        end

        // Truncation at MAX_BYTES, remainder re-granted
        clear_logs();
        for (int i = 0; i < 6; i++) push(2, 8'hB0 + 8'(i), 1'b0);
        drive_inputs();
        run_until_idle("trunc", 1000);
        chk("trunc_pulses", trunc_seen, 1);
        chk("trunc_bytes", blog.size(), 6);
        chk("trunc_frames", glog.size(), 2);
        for (int i = 0; i < glog.size(); i++) chk("trunc_src", glog[i], 2);

        // Abandon after one byte
        clear_logs();
        push(0, 8'hC1, 1'b0);
        drive_inputs();
        run_until_idle("abandon", 500);
        chk("abandon_bytes", blog.size(), 1);
        chk("abandon_trunc", trunc_seen, 0);
        if (glog.size() > 0) chk("abandon_src", glog[0], 0);

        // Stall in LOAD with request held
        clear_logs();
        hold_valid = 1;
        push(1, 8'hD1, 1'b1);
        drive_inputs();
        for (int n = 0; n < 50; n++) begin
            cycle();
            chk("stall_send", uart_send, 0);
            chk("stall_gnt", gnt, 3'b010);
        end
        hold_valid = 0;
        drive_inputs();
        run_until_idle("stall", 500);
        chk("stall_bytes", blog.size(), 1);

        // Randomised traffic with random stalls and UART latency
        stall_pct = 25;
        for (int round = 0; round < 3; round++) begin
            clear_logs();
            for (int s = 0; s < NREQ; s++) begin
                int nf;
                nf = int'($urandom_range(3, 0));
                for (int f = 0; f < nf; f++) begin
                    int len;
                    len = int'($urandom_range(6, 1));
                    for (int b = 0; b < len; b++) push(s, 8'($urandom), (b == len - 1));
                end
            end
            drive_inputs();
            run_until_idle("random", 8000);
        end
        stall_pct = 0;
        chk("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
